// File: rtl/sram_rr_arbiter_if.sv
// Bundle of requester-side and SRAM-side signals around the shared-port arbiter.
// The arbiter uses the slave view; requesters plus the SRAM sit on the master view.
interface sram_rr_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ-1:0]            req_lock_i;
  logic [NUM_REQ-1:0]            req_we_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i;
  logic [NUM_REQ*STRB_WIDTH-1:0] req_wstrb_i;
  logic [NUM_REQ-1:0]            rsp_valid_o;
  logic [DATA_WIDTH-1:0]         rsp_rdata_o;
  logic                          mem_req_o;
  logic                          mem_we_o;
  logic [ADDR_WIDTH-1:0]         mem_addr_o;
  logic [DATA_WIDTH-1:0]         mem_wdata_o;
  logic [STRB_WIDTH-1:0]         mem_wstrb_o;
  logic [DATA_WIDTH-1:0]         mem_rdata_i;

  modport slave (
    input  req_valid_i, req_lock_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i,
    input  mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );

  modport master (
    output req_valid_i, req_lock_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i,
    output mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one SRAM native port among NUM_REQ requesters,
// with bounded grant locking for bursts and 1-cycle routed responses.
module sram_rr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_HOLD   = 4
) (
  input logic              clk_i,
  input logic              rst_ni,
  sram_rr_arbiter_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               lock_q, lock_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               rsp_we_q, rsp_we_d;

  logic [IDX_W-1:0]   gnt_idx_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic               found_s;
  logic               lock_live_s;
  logic [HOLD_W-1:0]  hold_base_s;

  // Offset is always below NUM_REQ, so a single subtraction performs the wrap.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return sum[IDX_W-1:0];
  endfunction

  // Grant selection: live lock owner first, otherwise first valid from rr_ptr upward.
  always_comb begin
    lock_live_s = lock_q && bus.req_valid_i[owner_q];
    found_s     = 1'b0;
    gnt_idx_s   = rr_ptr_q;
    if (!rst_ni) begin
      found_s = 1'b0;
    end else if (lock_live_s) begin
      found_s   = 1'b1;
      gnt_idx_s = owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found_s && bus.req_valid_i[wrap_add(rr_ptr_q, k)]) begin
          found_s   = 1'b1;
          gnt_idx_s = wrap_add(rr_ptr_q, k);
        end else begin
          found_s = found_s;
        end
      end
    end
    gnt_s = '0;
    if (found_s) begin
      gnt_s[gnt_idx_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  // Pointer, lock and hold bookkeeping plus the response pipeline stage.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    hold_base_s = lock_live_s ? hold_q : '0;
    if (lock_live_s) begin
      lock_d = lock_q;
      hold_d = hold_q;
    end else begin
      lock_d = 1'b0;
      hold_d = '0;
    end
    if (found_s) begin
      if (bus.req_lock_i[gnt_idx_s] && (int'(hold_base_s) < MAX_HOLD - 1)) begin
        lock_d  = 1'b1;
        owner_d = gnt_idx_s;
        hold_d  = hold_base_s + HOLD_W'(1);
      end else begin
        lock_d   = 1'b0;
        hold_d   = '0;
        rr_ptr_d = wrap_add(gnt_idx_s, 1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    rsp_valid_d = gnt_s;
    rsp_we_d    = found_s ? bus.req_we_i[gnt_idx_s] : 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      lock_q      <= 1'b0;
      hold_q      <= '0;
      rsp_valid_q <= '0;
      rsp_we_q    <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      lock_q      <= lock_d;
      hold_q      <= hold_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

  assign bus.req_ready_o = gnt_s;
  assign bus.mem_req_o   = found_s;
  assign bus.mem_we_o    = bus.req_we_i[gnt_idx_s];
  assign bus.mem_addr_o  = bus.req_addr_i[gnt_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.mem_wdata_o = bus.req_wdata_i[gnt_idx_s*DATA_WIDTH +: DATA_WIDTH];
  assign bus.mem_wstrb_o = bus.req_wstrb_i[gnt_idx_s*STRB_WIDTH +: STRB_WIDTH];

  // A response pending when reset asserts is suppressed immediately.
  assign bus.rsp_valid_o = rst_ni ? rsp_valid_q : '0;
  assign bus.rsp_rdata_o = (rst_ni && (|rsp_valid_q) && !rsp_we_q) ? bus.mem_rdata_i : '0;
endmodule
